regfile_dump: RTL and testbench



---
 rtl/regfile_dump_if.sv | 27 ++
 rtl/regfile_dump.sv | 99 +++++++++
 tb/tb_regfile_dump.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Output stream of the register-file dump engine: one register value per
// transfer, tagged with its index and an end-of-range marker.
interface regfile_dump_if #(
  parameter int WIDTH = 64
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       out_idx;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Debug readout engine: walks register indices FIRST..LAST through one
// combinational register-file read port and streams each value out.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | ra = idx; capture rd into the output word
// HOLD  | out_valid high, word held stable until out_ready
// DONE  | done pulse after the LAST word was accepted; busy still high
module regfile_dump #(
  parameter int          WIDTH = 64,
  parameter int unsigned FIRST = 0,
  parameter int unsigned LAST  = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [4:0]       ra,
  input  logic [WIDTH-1:0] rd,
  regfile_dump_if.master   stream,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST);
  localparam logic [4:0] LAST_IDX  = 5'(LAST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] idx;

  // The register file answers ra within the same cycle, so the address is
  // simply the index register.
  assign ra   = idx;
  assign busy = (state != IDLE);

  // Dump sequencer: state, index and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= 5'd0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_idx   <= 5'd0;
      stream.out_last  <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over everything; a word accepted in the same cycle is
      // simply considered delivered, nothing needs undoing.
      if (abort && (state != IDLE)) begin
        state            <= IDLE;
        stream.out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              idx   <= FIRST_IDX;
              state <= LOAD;
            end
          end
          LOAD: begin
            stream.out_data  <= rd;
            stream.out_idx   <= idx;
            stream.out_last  <= (idx == LAST_IDX);
            stream.out_valid <= 1'b1;
            state            <= HOLD;
          end
          HOLD: begin
            if (stream.out_ready) begin
              stream.out_valid <= 1'b0;
              if (stream.out_last) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                idx   <= idx + 5'd1;
                state <= LOAD;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a full-range instance (0..31) and a narrow one
// (3..5) share a behavioural register file. Expected words are queued when a
// dump is started and popped as the DUT hands them over.
module tb_regfile_dump;

  localparam logic [63:0] BASE = 64'h1000_0000_0000_0000;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } word_t;

  typedef struct {
    int          stall;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_f = 1'b0, abort_f = 1'b0;
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [4:0]  ra_f, ra_b;
  logic [63:0] rd_f, rd_b;
  logic        busy_f, done_f, busy_b, done_b;

  logic [63:0] regs [32];
  logic        we = 1'b0;
  logic [4:0]  wa = 5'd0;
  logic [63:0] wd = 64'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_words_f = 0;
  int n_words_b = 0;

  word_t q_full[$];
  word_t q_bp[$];
  word_t e_f, e_b, hold_f, hold_b;
  bit    stall_f = 0, stall_b = 0;

  regfile_dump_if #(.WIDTH(64)) sf ();
  regfile_dump_if #(.WIDTH(64)) sb ();

  regfile_dump #(.WIDTH(64), .FIRST(0), .LAST(31)) dut_full (
    .clk(clk), .reset(reset), .start(start_f), .abort(abort_f),
    .ra(ra_f), .rd(rd_f), .stream(sf), .busy(busy_f), .done(done_f)
  );

  regfile_dump #(.WIDTH(64), .FIRST(3), .LAST(5)) dut_bp (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .ra(ra_b), .rd(rd_b), .stream(sb), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Register file: synchronous write, combinational read, x0 hardwired to 0.
  always @(posedge clk) if (we) regs[wa] <= wd;
  assign rd_f = (ra_f == 5'd0) ? 64'd0 : regs[ra_f];
  assign rd_b = (ra_b == 5'd0) ? 64'd0 : regs[ra_b];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the words a full-range dump should deliver, using the bench's own
  // register contents; ovr8 models a write to x8 landing mid-dump.
  task automatic push_full(input int first, input int last, input bit ovr8);
    word_t w;
    for (int i = first; i <= last; i++) begin
      w.idx  = 5'(i);
      w.data = (i == 0) ? 64'd0 : ((ovr8 && i == 8) ? 64'hBB : regs[i]);
      w.last = (i == 31);
      q_full.push_back(w);
    end
  endtask

  // Start pulse sampled at "edge 0"; returns t0 such that cyc - t0 is the
  // cycle number (1 = LOAD of the first word).
  task automatic pulse_start_f(output int t0);
    start_f = 1'b1;
    step();
    start_f = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_cycle(input int t0, input int n);
    while (cyc - t0 < n) step();
  endtask

  task automatic wait_done_f(input string name, input int budget);
    int k;
    k = 0;
    while (!done_f && k < budget) begin
      step();
      k++;
    end
    chk(name, done_f, 1'b1);
    step();
  endtask

  // Scoreboard: pop on every handshake; also check that a stalled word holds.
  always @(negedge clk) begin
    if (reset) begin
      stall_f = 0;
      stall_b = 0;
    end else begin
      if (stall_f && sf.out_valid) begin
        chk("full_stall_data", sf.out_data, hold_f.data);
        chk("full_stall_idx", 64'(sf.out_idx), 64'(hold_f.idx));
      end
      if (sf.out_valid && sf.out_ready) begin
        n_words_f++;
        if (q_full.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL full_extra_word: got idx %0d expected no word", sf.out_idx);
        end else begin
          e_f = q_full.pop_front();
          chk("full_data", sf.out_data, e_f.data);
          chk("full_idx", 64'(sf.out_idx), 64'(e_f.idx));
          chk("full_last", 64'(sf.out_last), 64'(e_f.last));
        end
      end
      stall_f = sf.out_valid && !sf.out_ready;
      hold_f  = '{sf.out_idx, sf.out_data, sf.out_last};

      if (stall_b && sb.out_valid) begin
        chk("bp_stall_data", sb.out_data, hold_b.data);
        chk("bp_stall_idx", 64'(sb.out_idx), 64'(hold_b.idx));
        chk("bp_stall_last", 64'(sb.out_last), 64'(hold_b.last));
      end
      if (sb.out_valid && sb.out_ready) begin
        n_words_b++;
        if (q_bp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bp_extra_word: got idx %0d expected no word", sb.out_idx);
        end else begin
          e_b = q_bp.pop_front();
          chk("bp_data", sb.out_data, e_b.data);
          chk("bp_idx", 64'(sb.out_idx), 64'(e_b.idx));
          chk("bp_last", 64'(sb.out_last), 64'(e_b.last));
        end
      end
      stall_b = sb.out_valid && !sb.out_ready;
      hold_b  = '{sb.out_idx, sb.out_data, sb.out_last};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    vec_t tv[3];
    int   k;

    sf.out_ready = 1'b1;
    sb.out_ready = 1'b0;

    // Preload x1..x31 through the write port while in reset.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      wa = 5'(i);
      wd = BASE + 64'(i);
      step();
    end
    we = 1'b0;

    chk("rst_valid", 64'(sf.out_valid), 64'd0);
    chk("rst_data", sf.out_data, 64'd0);
    chk("rst_ra", 64'(ra_f), 64'd0);
    chk("rst_busy", 64'(busy_f), 64'd0);
    chk("rst_done", 64'(done_f), 64'd0);
    reset = 1'b0;
    step();

    // Full dump, ready always high: exact busy/done timeline.
    n_words_f = 0;
    push_full(0, 31, 0);
    pulse_start_f(t0);
    for (int n = 1; n <= 70; n++) begin
      chk($sformatf("full_busy_c%0d", n), 64'(busy_f), 64'(n <= 65));
      chk($sformatf("full_done_c%0d", n), 64'(done_f), 64'(n == 65));
      if (n == 2) chk("full_first_valid_c2", 64'(sf.out_valid), 64'd1);
      step();
    end
    chk("full_words", 64'(n_words_f), 64'd32);
    chk("full_queue_empty", 64'(q_full.size()), 64'd0);

    // Concurrent writes plus repeated start pulses while busy.
    n_words_f = 0;
    push_full(0, 31, 1);
    pulse_start_f(t0);
    for (int n = 1; n <= 75; n++) begin
      start_f = ((n % 3) == 0) && (n <= 60);
      we = (n == 15) || (n == 16);
      wa = (n == 15) ? 5'd7 : 5'd8;
      wd = (n == 15) ? 64'hAA : 64'hBB;
      step();
    end
    start_f = 1'b0;
    we = 1'b0;
    chk("busy_start_words", 64'(n_words_f), 64'd32);
    chk("busy_start_idle", 64'(busy_f), 64'd0);
    chk("busy_start_queue", 64'(q_full.size()), 64'd0);

    // Abort while HOLD has idx 10 and out_ready low.
    push_full(0, 9, 0);
    pulse_start_f(t0);
    wait_cycle(t0, 22);
    chk("abort_hold_idx", 64'(sf.out_idx), 64'd10);
    sf.out_ready = 1'b0;
    abort_f = 1'b1;
    step();
    abort_f = 1'b0;
    chk("abort_valid", 64'(sf.out_valid), 64'd0);
    chk("abort_busy", 64'(busy_f), 64'd0);
    for (int n = 0; n < 4; n++) begin
      chk("abort_no_done", 64'(done_f), 64'd0);
      step();
    end
    chk("abort_queue", 64'(q_full.size()), 64'd0);
    sf.out_ready = 1'b1;
    push_full(0, 31, 0);
    pulse_start_f(t0);
    wait_done_f("abort_restart_done", 200);
    chk("abort_restart_queue", 64'(q_full.size()), 64'd0);

    // Reset while HOLD has idx 4.
    push_full(0, 3, 0);
    pulse_start_f(t0);
    wait_cycle(t0, 10);
    sf.out_ready = 1'b0;
    reset = 1'b1;
    step();
    chk("rstmid_valid", 64'(sf.out_valid), 64'd0);
    chk("rstmid_data", sf.out_data, 64'd0);
    chk("rstmid_idx", 64'(sf.out_idx), 64'd0);
    chk("rstmid_last", 64'(sf.out_last), 64'd0);
    chk("rstmid_ra", 64'(ra_f), 64'd0);
    chk("rstmid_busy", 64'(busy_f), 64'd0);
    chk("rstmid_done", 64'(done_f), 64'd0);
    reset = 1'b0;
    sf.out_ready = 1'b1;
    step();
    chk("rstmid_queue", 64'(q_full.size()), 64'd0);
    n_words_f = 0;
    push_full(0, 31, 0);
    pulse_start_f(t0);
    wait_done_f("rstmid_restart_done", 200);
    chk("rstmid_restart_words", 64'(n_words_f), 64'd32);

    // Backpressure on the 3..5 instance: 4 stalled cycles per word.
    tv[0] = '{4, 5'd3, BASE + 64'd3, 1'b0};
    tv[1] = '{4, 5'd4, BASE + 64'd4, 1'b0};
    tv[2] = '{4, 5'd5, BASE + 64'd5, 1'b1};
    n_words_b = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int v = 0; v < 3; v++) begin
      q_bp.push_back('{tv[v].idx, tv[v].data, tv[v].last});
      k = 0;
      while (!sb.out_valid && k < 20) begin
        step();
        k++;
      end
      chk($sformatf("bp_valid_wait_%0d", v), 64'(sb.out_valid), 64'd1);
      repeat (tv[v].stall) step();
      sb.out_ready = 1'b1;
      step();
      sb.out_ready = 1'b0;
      chk($sformatf("bp_done_after_%0d", v), 64'(done_b), 64'(tv[v].last));
    end
    step();
    chk("bp_done_clear", 64'(done_b), 64'd0);
    chk("bp_busy_clear", 64'(busy_b), 64'd0);
    chk("bp_words", 64'(n_words_b), 64'd3);
    chk("bp_queue", 64'(q_bp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
